// File: rtl/addr8s_tmr_sched_if.sv
// Requester / consumer bundle for the shared-adder scheduler.
// The master side presents requests and accepts responses; the slave side is the scheduler.
interface addr8s_tmr_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [8:0]        rsp_sum;
    logic              rsp_fault;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_fault, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_fault, rsp_err
    );
endinterface

// File: rtl/addr8s_tmr_sched.sv
// Round-robin scheduler sharing one external 8-bit adder among NREQ requesters,
// with temporal redundancy: two compared passes, plus a voting third pass on mismatch.
module addr8s_tmr_sched #(
    parameter int NREQ   = 4,
    parameter bit CMP_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    addr8s_tmr_sched_if.slave       bus,
    output logic [7:0]              add_a,
    output logic [7:0]              add_b,
    input  logic [8:0]              add_sum,
    output logic [7:0]              fault_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC1 = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_EXEC3 = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [2:0]  ptr_r, gid_r;
    logic [7:0]  add_a_r, add_b_r;
    logic [8:0]  r1_r, r2_r;
    logic [8:0]  rsp_sum_r;
    logic        rsp_valid_r, rsp_fault_r, rsp_err_r;
    logic [7:0]  fault_cnt_r;

    logic [7:0]  vld8_s;
    logic [63:0] a64_s, b64_s;
    logic [3:0]  scan_idx_s;
    logic        gnt_any_s;
    logic [2:0]  gnt_id_s;
    logic [7:0]  gnt_oh8_s;
    logic        rsp_load_s, rsp_fault_nxt_s, rsp_err_nxt_s, hs_s;
    logic [8:0]  rsp_sum_nxt_s;

    // Zero-extend requester buses to the 8-slot maximum so indices are fixed width
    assign vld8_s = 8'(bus.req_valid);
    assign a64_s  = 64'(bus.req_a);
    assign b64_s  = 64'(bus.req_b);

    // Round-robin search: first pending requester at or after ptr, wrapping
    always_comb begin
        gnt_any_s  = 1'b0;
        gnt_id_s   = 3'd0;
        scan_idx_s = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = {1'b0, ptr_r} + 4'(k);
            if (scan_idx_s >= 4'(NREQ)) begin
                scan_idx_s = scan_idx_s - 4'(NREQ);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!gnt_any_s && vld8_s[scan_idx_s[2:0]]) begin
                gnt_any_s = 1'b1;
                gnt_id_s  = scan_idx_s[2:0];
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    assign gnt_oh8_s = 8'd1 << gnt_id_s;
    assign hs_s      = rsp_valid_r & bus.rsp_ready;

    // Next-state, accept strobe and vote resolution
    always_comb begin
        state_nxt_s     = state_r;
        bus.req_ready   = '0;
        rsp_load_s      = 1'b0;
        rsp_sum_nxt_s   = r1_r;
        rsp_fault_nxt_s = 1'b0;
        rsp_err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    bus.req_ready = gnt_oh8_s[NREQ-1:0];
                    state_nxt_s   = ST_EXEC1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_EXEC1: begin
                if (CMP_EN == 1'b0) begin
                    rsp_load_s    = 1'b1;
                    rsp_sum_nxt_s = add_sum;
                    state_nxt_s   = ST_RESP;
                end else begin
                    state_nxt_s   = ST_EXEC2;
                end
            end
            ST_EXEC2: begin
                if (add_sum == r1_r) begin
                    rsp_load_s  = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_EXEC3;
                end
            end
            ST_EXEC3: begin
                rsp_load_s  = 1'b1;
                state_nxt_s = ST_RESP;
                if (add_sum == r1_r) begin
                    rsp_fault_nxt_s = 1'b1;
                end else if (add_sum == r2_r) begin
                    rsp_sum_nxt_s   = r2_r;
                    rsp_fault_nxt_s = 1'b1;
                end else begin
                    rsp_err_nxt_s   = 1'b1;
                end
            end
            ST_RESP: begin
                if (hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, pass capture, response registers, fault counter and pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= 3'd0;
            gid_r       <= 3'd0;
            add_a_r     <= 8'd0;
            add_b_r     <= 8'd0;
            r1_r        <= 9'd0;
            r2_r        <= 9'd0;
            rsp_sum_r   <= 9'd0;
            rsp_valid_r <= 1'b0;
            rsp_fault_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            fault_cnt_r <= 8'd0;
        end else begin
            if (state_r == ST_IDLE && gnt_any_s) begin
                add_a_r <= a64_s[{gnt_id_s, 3'b000} +: 8];
                add_b_r <= b64_s[{gnt_id_s, 3'b000} +: 8];
                gid_r   <= gnt_id_s;
            end
            if (state_r == ST_EXEC1) begin
                r1_r <= add_sum;
            end
            if (state_r == ST_EXEC2) begin
                r2_r <= add_sum;
            end
            if (rsp_load_s) begin
                rsp_valid_r <= 1'b1;
                rsp_sum_r   <= rsp_sum_nxt_s;
                rsp_fault_r <= rsp_fault_nxt_s;
                rsp_err_r   <= rsp_err_nxt_s;
                if ((rsp_fault_nxt_s || rsp_err_nxt_s) && fault_cnt_r != 8'hFF) begin
                    fault_cnt_r <= fault_cnt_r + 8'd1;
                end
            end else if (hs_s) begin
                rsp_valid_r <= 1'b0;
                ptr_r       <= (gid_r == 3'(NREQ - 1)) ? 3'd0 : gid_r + 3'd1;
            end
        end
    end

    assign add_a         = add_a_r;
    assign add_b         = add_b_r;
    assign fault_cnt     = fault_cnt_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = gid_r;
    assign bus.rsp_sum   = rsp_sum_r;
    assign bus.rsp_fault = rsp_fault_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_addr8s_tmr_sched.sv
// Directed + randomized bench for addr8s_tmr_sched with a fault-injecting adder model
// and a rule-level reference for arbitration, voting, latency and the fault counter.
module tb_addr8s_tmr_sched;

    localparam int NREQ = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] add_a, add_b;
    logic [8:0] add_sum;
    logic [7:0] fault_cnt;

    int checks = 0;
    int errors = 0;
    int adder_mode = 0;
    int pass_cyc = 0;
    int ptr_m = 0;
    int cnt_m = 0;

    addr8s_tmr_sched_if #(.NREQ(NREQ)) bus ();

    addr8s_tmr_sched #(.NREQ(NREQ), .CMP_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .fault_cnt (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pass number since the last accept: 1 = first execution cycle
    always @(posedge clk) begin
        if (|(bus.req_valid & bus.req_ready)) pass_cyc <= 1;
        else if (pass_cyc != 0 && pass_cyc < 7) pass_cyc <= pass_cyc + 1;
    end

    function automatic logic [8:0] exact_sum(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return 9'(s);
    endfunction

    function automatic logic [8:0] pass_val(input int mode, input int pass, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] e;
        e = exact_sum(a, b);
        if (mode == 1) return (pass == 2) ? (e ^ 9'd1) : e;
        if (mode == 2) return 9'(pass);
        return e;
    endfunction

    // Shared adder model with per-pass corruption
    always_comb add_sum = pass_val(adder_mode, pass_cyc, add_a, add_b);

    function automatic void vote_ref(input logic [8:0] p1, input logic [8:0] p2, input logic [8:0] p3,
                                     output logic [8:0] s, output logic f, output logic e, output int lat);
        if (p1 == p2)      begin s = p1; f = 1'b0; e = 1'b0; lat = 3; end
        else if (p3 == p1) begin s = p1; f = 1'b1; e = 1'b0; lat = 4; end
        else if (p3 == p2) begin s = p2; f = 1'b1; e = 1'b0; lat = 4; end
        else               begin s = p1; f = 1'b0; e = 1'b1; lat = 4; end
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve one request from whatever is pending; keep=1 re-presents new operands for the winner
    task automatic serve(input int mode, input bit keep, input int stall);
        int g, n, lat, lat_exp;
        logic [7:0] a, b;
        logic [8:0] s_exp, s_hold;
        logic f_exp, e_exp;
        logic [NREQ-1:0] saved;
        adder_mode    = mode;
        bus.rsp_ready = (stall == 0);
        #1;
        g = rr_pick(bus.req_valid, ptr_m);
        if (g < 0) g = 0;
        n = 0;
        while (bus.req_ready == '0 && n < 16) begin @(negedge clk); #1; n++; end
        chk("grant", 16'(bus.req_ready), 16'(1 << g));
        a = bus.req_a[8*g +: 8];
        b = bus.req_b[8*g +: 8];
        @(negedge clk);
        if (keep) begin
            bus.req_a[8*g +: 8] = 8'($urandom);
            bus.req_b[8*g +: 8] = 8'($urandom);
        end else begin
            bus.req_valid[g] = 1'b0;
        end
        vote_ref(pass_val(mode, 1, a, b), pass_val(mode, 2, a, b), pass_val(mode, 3, a, b),
                 s_exp, f_exp, e_exp, lat_exp);
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin @(negedge clk); lat++; end
        chk("latency", 16'(lat), 16'(lat_exp));
        chk("rsp_id", 16'(bus.rsp_id), 16'(g));
        chk("rsp_sum", 16'(bus.rsp_sum), 16'(s_exp));
        chk("rsp_fault", 16'(bus.rsp_fault), 16'(f_exp));
        chk("rsp_err", 16'(bus.rsp_err), 16'(e_exp));
        if (f_exp || e_exp) cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
        chk("fault_cnt", 16'(fault_cnt), 16'(cnt_m));
        if (stall > 0) begin
            saved  = bus.req_valid;
            s_hold = s_exp;
            bus.req_valid = '1;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk); #1;
                chk("stall_valid", 16'(bus.rsp_valid), 16'd1);
                chk("stall_sum", 16'(bus.rsp_sum), 16'(s_hold));
                chk("stall_id", 16'(bus.rsp_id), 16'(g));
                chk("stall_noready", 16'(bus.req_ready), 16'd0);
            end
            bus.req_valid = saved;
            bus.rsp_ready = 1'b1;
        end
        ptr_m = (g + 1) % NREQ;
        @(negedge clk);
        chk("rsp_drop", 16'(bus.rsp_valid), 16'd0);
    endtask

    initial begin
        int guard;
        logic seen;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_add_a", 16'(add_a), 16'd0);
        chk("rst_add_b", 16'(add_b), 16'd0);
        chk("rst_req_ready", 16'(bus.req_ready), 16'd0);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rst_rsp_id", 16'(bus.rsp_id), 16'd0);
        chk("rst_rsp_sum", 16'(bus.rsp_sum), 16'd0);
        chk("rst_rsp_fault", 16'(bus.rsp_fault), 16'd0);
        chk("rst_rsp_err", 16'(bus.rsp_err), 16'd0);
        chk("rst_fault_cnt", 16'(fault_cnt), 16'd0);

        // All requesters held high: order 0,1,2,3,0,1
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[8*i +: 8] = 8'($urandom);
            bus.req_b[8*i +: 8] = 8'($urandom);
        end
        bus.req_valid = '1;
        for (int k = 0; k < 6; k++) serve(0, 1'b1, 0);
        bus.req_valid = '0;

        // Directed arithmetic corners
        bus.req_a[7:0] = 8'h7F; bus.req_b[7:0] = 8'h01; bus.req_valid = 4'b0001;
        serve(0, 1'b0, 0);
        bus.req_a[23:16] = 8'h80; bus.req_b[23:16] = 8'h80; bus.req_valid = 4'b0100;
        serve(0, 1'b0, 0);
        bus.req_a[23:16] = 8'hFF; bus.req_b[23:16] = 8'h01; bus.req_valid = 4'b0100;
        serve(0, 1'b0, 0);

        // Single corrupted pass resolved by vote
        bus.req_a[31:24] = 8'd5; bus.req_b[31:24] = 8'd3; bus.req_valid = 4'b1000;
        serve(1, 1'b0, 0);
        chk("fcnt_one", 16'(fault_cnt), 16'd1);

        // Random pending sets and operands
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req_a[8*i +: 8] = 8'($urandom);
                bus.req_b[8*i +: 8] = 8'($urandom);
            end
            bus.req_valid = 4'($urandom_range(1, 15));
            guard = 0;
            while (bus.req_valid != '0 && guard < 8) begin serve(0, 1'b0, 0); guard++; end
        end

        // Consumer back-pressure for 5 cycles
        bus.req_a[15:8] = 8'h3C; bus.req_b[15:8] = 8'hE2; bus.req_valid = 4'b0010;
        serve(0, 1'b0, 5);

        // No-majority responses until the counter saturates
        for (int k = 0; k < 300; k++) begin
            bus.req_a[8*(k%NREQ) +: 8] = 8'($urandom);
            bus.req_b[8*(k%NREQ) +: 8] = 8'($urandom);
            bus.req_valid = 4'(1 << (k % NREQ));
            serve(2, 1'b0, 0);
        end
        chk("fcnt_sat", 16'(fault_cnt), 16'd255);

        // Reset during the second pass discards the request
        adder_mode = 0;
        bus.req_a[15:8] = 8'h21; bus.req_b[15:8] = 8'h12; bus.req_valid = 4'b0010;
        #1;
        guard = 0;
        while (bus.req_ready == '0 && guard < 16) begin @(negedge clk); #1; guard++; end
        chk("mid_grant", 16'(bus.req_ready), 16'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_add_a", 16'(add_a), 16'd0);
        chk("arst_add_b", 16'(add_b), 16'd0);
        chk("arst_req_ready", 16'(bus.req_ready), 16'd0);
        chk("arst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("arst_rsp_id", 16'(bus.rsp_id), 16'd0);
        chk("arst_rsp_sum", 16'(bus.rsp_sum), 16'd0);
        chk("arst_rsp_flags", 16'({bus.rsp_fault, bus.rsp_err}), 16'd0);
        chk("arst_fault_cnt", 16'(fault_cnt), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        cnt_m = 0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin @(negedge clk); seen = seen | bus.rsp_valid; end
        chk("no_rsp_after_rst", 16'(seen), 16'd0);

        // Pointer restarts at 0 after reset
        bus.req_a[15:8] = 8'h10; bus.req_b[15:8] = 8'hF0;
        bus.req_a[31:24] = 8'h40; bus.req_b[31:24] = 8'h41;
        bus.req_valid = 4'b1010;
        serve(0, 1'b0, 0);
        serve(0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
